// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-key 2-FF synchronizer, counter debouncer and press/release pulse detector.
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat o_press pulses while a key stays held.
`timescale 1ns/1ps

module button_conditioner #(
    parameter int N_KEYS          = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RPT_DELAY       = 25000000,
    parameter int RPT_PERIOD      = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(RPT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(RPT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);
`endif

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (RPT_DELAY < 1 || RPT_PERIOD < 1 || RPT_PERIOD > RPT_DELAY) begin : g_bad_repeat
        $error("RPT_PERIOD must be in 1..RPT_DELAY");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_HELD,
        S_WAIT_RELEASE
    } state_t;

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = ~i_key_n;
        sync2_d = sync1_q;
    end

    // Reset value 0 means "released", so a key held through reset must debounce again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             press_any;
        logic             k;

        assign k = sync2_q[g];

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (k) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_WAIT_PRESS;
                    end
                end
                S_WAIT_PRESS: begin
                    if (!k) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_HELD;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HELD: begin
                    if (!k) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (k) begin
                        cnt_d   = '0;
                        state_d = S_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = S_IDLE;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end

`ifdef BUTTON_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             rpt_phase_q, rpt_phase_d;
        logic             rpt_fire;

        // rpt_phase_q selects the first-repeat delay (0) or the steady repeat period (1).
        always_comb begin
            rpt_d       = rpt_q;
            rpt_phase_d = rpt_phase_q;
            rpt_fire    = 1'b0;
            if (state_q == S_HELD && k) begin
                if (rpt_q == (rpt_phase_q ? RPT_PER_LAST : RPT_DLY_LAST)) begin
                    rpt_fire    = 1'b1;
                    rpt_d       = '0;
                    rpt_phase_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + RPT_ONE;
                end
            end
            if (state_d == S_IDLE || (state_q == S_WAIT_PRESS && state_d == S_HELD)) begin
                rpt_d       = '0;
                rpt_phase_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rpt_q       <= '0;
                rpt_phase_q <= 1'b0;
            end else begin
                rpt_q       <= rpt_d;
                rpt_phase_q <= rpt_phase_d;
            end
        end

        assign press_any = press_d | rpt_fire;
`else
        assign press_any = press_d;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_any;
                release_q <= release_d;
            end
        end

        assign o_level[g]   = (state_q == S_HELD) || (state_q == S_WAIT_RELEASE);
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner with a run-length reference model.
`timescale 1ns/1ps

module tb_button_conditioner;

    localparam int NK = 7;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] i_key_n = '1;
    logic [NK-1:0] o_level, o_press, o_release;

    int total = 0;
    int bad = 0;

    button_conditioner #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(DB),
        .RPT_DELAY(RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_key_n(i_key_n),
        .o_level(o_level),
        .o_press(o_press),
        .o_release(o_release)
    );

    always #5 clk = ~clk;

    // Model: the level flips once DB consecutive synchronized samples disagree with it.
    logic [NK-1:0] m_d1, m_d2, m_level, m_press, m_release;
    int m_run[NK];
    int m_rep[NK];

    typedef struct {
        logic [NK-1:0] key_n;
        int            cycles;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = '0;
        m_d2 = '0;
        m_level = '0;
        m_press = '0;
        m_release = '0;
        for (int b = 0; b < NK; b++) begin
            m_run[b] = 0;
            m_rep[b] = 0;
        end
    endtask

    task automatic model_edge(input logic rst_ok, input logic [NK-1:0] key_n);
        logic [NK-1:0] kv;
        logic held;
        if (!rst_ok) begin
            model_reset();
            return;
        end
        kv = m_d2;
        m_d2 = m_d1;
        m_d1 = ~key_n;
        m_press = '0;
        m_release = '0;
        for (int b = 0; b < NK; b++) begin
            held = m_level[b] && (m_run[b] == 0);
            if (kv[b] != m_level[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == DB) begin
                m_level[b] = !m_level[b];
                m_run[b] = 0;
                m_rep[b] = 0;
                if (m_level[b]) m_press[b] = 1'b1;
                else m_release[b] = 1'b1;
            end
`ifdef BUTTON_AUTOREPEAT_EN
            else if (held && kv[b]) begin
                m_rep[b]++;
                if (m_rep[b] == RD || (m_rep[b] > RD && (m_rep[b] - RD) % RP == 0))
                    m_press[b] = 1'b1;
            end
`else
            else if (held && kv[b]) begin
                m_rep[b]++;
            end
`endif
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(rst_n, i_key_n);
            #1;
            check("model", {11'd0, o_level, o_press, o_release}, {11'd0, m_level, m_press, m_release});
        end
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_out", {11'd0, o_level, o_press, o_release}, 32'd0);
    endtask

    initial begin
        int hold[NK];
        logic [NK-1:0] kn;
        logic exp_p;

        model_reset();
        tbl.push_back('{7'h7E, 3,  7'h00, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 10, 7'h00, 7'h00, 7'h00});
        tbl.push_back('{7'h6F, 5,  7'h00, 7'h00, 7'h00});
        tbl.push_back('{7'h6F, 1,  7'h10, 7'h10, 7'h00});
        tbl.push_back('{7'h6F, 1,  7'h10, 7'h00, 7'h00});
        tbl.push_back('{7'h6F, 13, 7'h10, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 5,  7'h10, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 1,  7'h00, 7'h00, 7'h10});
        tbl.push_back('{7'h7F, 1,  7'h00, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 6,  7'h00, 7'h00, 7'h00});
        tbl.push_back('{7'h7B, 10, 7'h04, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 2,  7'h04, 7'h00, 7'h00});
        tbl.push_back('{7'h7B, 9,  7'h04, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 5,  7'h04, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 1,  7'h00, 7'h00, 7'h04});
        tbl.push_back('{7'h7F, 6,  7'h00, 7'h00, 7'h00});
        tbl.push_back('{7'h7E, 2,  7'h00, 7'h00, 7'h00});
        tbl.push_back('{7'h3E, 4,  7'h01, 7'h01, 7'h00});
        tbl.push_back('{7'h3E, 1,  7'h01, 7'h00, 7'h00});
        tbl.push_back('{7'h3E, 1,  7'h41, 7'h40, 7'h00});
        tbl.push_back('{7'h3E, 1,  7'h41, 7'h00, 7'h00});
        tbl.push_back('{7'h7F, 6,  7'h00, 7'h00, 7'h41});
        tbl.push_back('{7'h7F, 8,  7'h00, 7'h00, 7'h00});

        // Reset with every key held, then the whole bank must debounce as a new press.
        rst_n = 1'b0;
        i_key_n = 7'h00;
        step(4);
        check("rst_level", o_level, 7'h00);
        check("rst_press", o_press, 7'h00);
        check("rst_release", o_release, 7'h00);
        rst_n = 1'b1;
        step(5);
        check("rst_rel_t5_press", o_press, 7'h00);
        step(1);
        check("rst_rel_t6_press", o_press, 7'h7F);
        check("rst_rel_t6_level", o_level, 7'h7F);
        step(1);
        check("rst_rel_t7_press", o_press, 7'h00);
        check("rst_rel_t7_level", o_level, 7'h7F);
        i_key_n = 7'h7F;
        step(12);

        foreach (tbl[i]) begin
            i_key_n = tbl[i].key_n;
            step(tbl[i].cycles);
            check($sformatf("vec%0d_level", i), o_level, tbl[i].lvl);
            check($sformatf("vec%0d_press", i), o_press, tbl[i].prs);
            check($sformatf("vec%0d_release", i), o_release, tbl[i].rel);
        end

        // Auto-repeat timeline on key1 (only the first pulse without the feature).
        i_key_n = 7'h7D;
        for (int t = 1; t <= 45; t++) begin
            step(1);
            exp_p = (t == 6);
`ifdef BUTTON_AUTOREPEAT_EN
            if (t >= 16 && t <= 34 && (t - 16) % 3 == 0) exp_p = 1'b1;
`endif
            check($sformatf("rpt_press_t%0d", t), o_press[1], exp_p);
            check($sformatf("rpt_level_t%0d", t), o_level[1], (t >= 6 && t < 39));
            if (t == 33) i_key_n = 7'h7F;
        end
        step(4);

        // Reset mid-hold aborts immediately; key still held must re-debounce.
        i_key_n = 7'h77;
        step(10);
        check("midhold_level", o_level, 7'h08);
        async_reset();
        step(2);
        rst_n = 1'b1;
        step(5);
        check("rehold_t5_press", o_press, 7'h00);
        step(1);
        check("rehold_t6_press", o_press, 7'h08);
        i_key_n = 7'h7F;
        step(10);

        kn = 7'h7F;
        for (int b = 0; b < NK; b++) hold[b] = $urandom_range(0, 5);
        for (int c = 0; c < 900; c++) begin
            for (int b = 0; b < NK; b++) begin
                if (hold[b] == 0) begin
                    kn[b] = ~kn[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 40) : $urandom_range(1, 6);
                end else begin
                    hold[b]--;
                end
            end
            i_key_n = kn;
            step(1);
            if (c == 450) begin
                async_reset();
                step(2);
                rst_n = 1'b1;
            end
        end
        i_key_n = 7'h7F;
        step(12);
        check("final_idle", {11'd0, o_level, o_press, o_release}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
